periph_port_arbiter: RTL

//  Shares the single HWPE peripheral (CSB-bridge) slave port between N_REQ masters, e.g. host core and config DMA.

---
 rtl/periph_arb_pkg.sv | 12 +
 rtl/periph_port_arbiter_rr.sv | 31 +++
 rtl/periph_port_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/periph_arb_pkg.sv
// Shared constants and types for the HWPE peripheral-port arbiter.
package periph_arb_pkg;

  // Read data returned on a watchdog-generated (synthetic) response.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  // Widest requester index the arbiter supports; narrower indices are
  // zero-extended into this type before being cut to the bus id width.
  localparam int REQ_IDX_W = 8;
  typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/periph_port_arbiter_rr.sv
// Round-robin arbiter: picks the first asserted request at or above ptr,
// wrapping modulo N_REQ. Purely combinational.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  // Scan from lowest to highest priority so the last hit is the winner.
  always_comb begin
    int cand;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (req[cand]) begin
        idx   = IW'(cand);
        valid = 1'b1;
      end
    end
    gnt = '0;
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/periph_port_arbiter.sv
// Shares one HWPE peripheral slave port (CSB bridge) between N_REQ masters.
// Round-robin grant, in-order outstanding FIFO, responses routed to issuer.
// Optional response watchdog enabled by defining PERIPH_ARB_TIMEOUT_EN.
module periph_port_arbiter
  import periph_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ID_WIDTH    = 1,
  parameter int MAX_OUTST   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      s_req_i,
  input  logic [N_REQ*32-1:0]   s_add_i,
  input  logic [N_REQ-1:0]      s_wen_i,
  input  logic [N_REQ*4-1:0]    s_be_i,
  input  logic [N_REQ*32-1:0]   s_data_i,
  output logic [N_REQ-1:0]      s_gnt_o,
  output logic [31:0]           s_r_data_o,
  output logic [N_REQ-1:0]      s_r_valid_o,
  output logic                  m_req_o,
  output logic [31:0]           m_add_o,
  output logic                  m_wen_o,
  output logic [3:0]            m_be_o,
  output logic [31:0]           m_data_o,
  output logic [ID_WIDTH-1:0]   m_id_o,
  input  logic                  m_gnt_i,
  input  logic [31:0]           m_r_data_i,
  input  logic                  m_r_valid_i,
  input  logic [ID_WIDTH-1:0]   m_r_id_i,
  output logic                  err_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = $clog2(MAX_OUTST);
  localparam int CW = $clog2(MAX_OUTST + 1);

  // Elaboration-time parameter sanity checks.
  if (N_REQ < 2 || ID_WIDTH < IW || ID_WIDTH > REQ_IDX_W) begin : g_bad_id_width
    $error("periph_port_arbiter: need N_REQ>=2 and clog2(N_REQ) <= ID_WIDTH <= REQ_IDX_W");
  end
  if (MAX_OUTST < 2 || (MAX_OUTST & (MAX_OUTST - 1)) != 0) begin : g_bad_depth
    $error("periph_port_arbiter: MAX_OUTST must be a power of 2, >= 2");
  end
  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("periph_port_arbiter: TIMEOUT_CYC must be >= 2");
  end

  // Outputs are forced quiet while reset is held.
  logic run;
  assign run = ~rst;

  // Unpack the flat per-requester buses.
  logic [31:0] add_arr  [N_REQ];
  logic [31:0] data_arr [N_REQ];
  logic [3:0]  be_arr   [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign add_arr[gi]  = s_add_i[gi*32 +: 32];
    assign data_arr[gi] = s_data_i[gi*32 +: 32];
    assign be_arr[gi]   = s_be_i[gi*4 +: 4];
  end

  // State
  logic [IW-1:0]       rr_ptr_reg;
  logic [CW-1:0]       count_reg;
  logic [AW-1:0]       wr_ptr_reg;
  logic [AW-1:0]       rd_ptr_reg;
  logic [ID_WIDTH-1:0] fifo_mem [MAX_OUTST];

  // Arbitration
  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req   (s_req_i),
    .ptr   (rr_ptr_reg),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  logic fifo_empty;
  logic fifo_full;
  assign fifo_empty = (count_reg == '0);
  assign fifo_full  = (count_reg == CW'(MAX_OUTST));

  // FIFO head: the requester owed the next response.
  logic [ID_WIDTH-1:0] head_id;
  req_idx_t            head_full;
  logic [IW-1:0]       head_idx;
  assign head_id   = fifo_mem[rd_ptr_reg];
  assign head_full = req_idx_t'(head_id);
  assign head_idx  = head_full[IW-1:0];

  // Winner index widened onto the bridge id field.
  req_idx_t            win_full;
  logic [ID_WIDTH-1:0] win_id;
  assign win_full = req_idx_t'(arb_idx);
  assign win_id   = win_full[ID_WIDTH-1:0];

  logic tmo_fire;
  logic resp_real;
  logic pop;
  logic handshake;

  // A real response pops only when something is outstanding; a stray one is dropped.
  assign resp_real = run & m_r_valid_i & ~fifo_empty;
  assign pop       = resp_real | tmo_fire;

  // A slot freed by this cycle's pop may be reused in the same cycle.
  assign m_req_o   = run & arb_valid & (~fifo_full | pop);
  assign handshake = m_req_o & m_gnt_i;

  assign m_id_o   = m_req_o ? win_id : '0;
  assign m_add_o  = m_req_o ? add_arr[arb_idx] : '0;
  assign m_data_o = m_req_o ? data_arr[arb_idx] : '0;
  assign m_be_o   = m_req_o ? be_arr[arb_idx] : '0;
  assign m_wen_o  = m_req_o & s_wen_i[arb_idx];

  assign s_gnt_o = handshake ? arb_gnt : '0;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rvalid
    assign s_r_valid_o[gi] = pop & (head_idx == IW'(gi));
  end

  assign s_r_data_o = !pop     ? 32'h0 :
                      tmo_fire ? TIMEOUT_RDATA : m_r_data_i;

  // In-order delivery is authoritative; a wrong id is flagged but not rerouted.
  assign err_o = (run & m_r_valid_i & (fifo_empty | (m_r_id_i != head_id))) | tmo_fire;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tmo_cnt_reg;

  // Watchdog fires on the TIMEOUT_CYC-th cycle without any response.
  assign tmo_fire = run & ~fifo_empty & ~m_r_valid_i &
                    (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

  // Watchdog counter: runs while work is outstanding, cleared by any response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_reg <= '0;
    end else if (m_r_valid_i || fifo_empty || tmo_fire) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Round-robin pointer advances past the winner only on a completed handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= '0;
    end else if (handshake) begin
      rr_ptr_reg <= (arb_idx == IW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  // Outstanding counter and FIFO pointers; push and pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (handshake) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)       rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({handshake, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage: issuer id of each granted transaction (contents need no reset).
  always_ff @(posedge clk) begin
    if (handshake) fifo_mem[wr_ptr_reg] <= win_id;
  end

endmodule
